lamp_counter_ctrl: RTL and testbench
====================================

# lamp_counter_ctrl

Parametrised lamp counter with integrated prescaler, replacing the ripple-clocked prescaler/counter pair on the board's LED bank. All logic runs in a single clock domain; advance is driven by a one-cycle tick enable instead of a derived clock. The block adds a programmable modulus, selectable count mode, synchronous load and a wrap pulse. It sits between the board clock generator output and the `lamps` pins.

## Interface
Parameters:
- `WIDTH`, 8: counter/lamp width, ≥1.
- `DIV`, 8388608: prescaler ratio in clk cycles per tick, ≥1 (default ≈1.19 Hz at 10 MHz).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `en` in 1: run enable; low freezes prescaler and counter.
- `mode` in 2: count mode, `mode_t` (UP=0, DOWN=1, BOUNCE=2, HOLD=3).
- `top_val` in WIDTH: modulus; counter range 0..top_val.
- `load` in 1: synchronous load strobe.
- `load_val` in WIDTH: value for load.
- `lamps` out WIDTH: counter value, registered.
- `tick` out 1: prescaler terminal pulse, combinational from registered state.
- `wrap` out 1: one-cycle registered pulse on range-end event.

## Operation
- Reset (`rst_n`=0): prescaler=0, `lamps`=0, direction=up, `wrap`=0, `tick`=0. Takes effect immediately, including mid-tick or mid-load.
- Prescaler: counts 0..DIV-1 while `en`=1, wraps to 0. `tick` = `en` && prescaler==DIV-1. DIV=1 gives `tick`=`en` every cycle. Width is max(1, $clog2(DIV)).
- Priority per edge: `load` > (`en` && `tick`) > hold.
- Load: `lamps` ← min(`load_val`, `top_val`), prescaler ← 0, direction ← up, `wrap` ← 0. Load is accepted regardless of `en`.
- On tick:
  - UP: if `lamps`≥`top_val`, `lamps`←0 and `wrap` pulses; else `lamps`+1.
  - DOWN: if `lamps`==0, `lamps`←`top_val` and `wrap` pulses; else `lamps`-1.
  - BOUNCE: direction up and `lamps`≥`top_val` → `lamps`←`top_val`-1, direction←down, `wrap` pulses. Direction down and `lamps`==0 → `lamps`←1, direction←up, `wrap` pulses. Otherwise step in the current direction. With `top_val`==0, `lamps` stays 0 and `wrap` pulses on every tick.
  - HOLD: `lamps` unchanged, `wrap`=0; prescaler keeps running.
- `top_val` lowered below `lamps`: UP wraps to 0 on the next tick; DOWN decrements normally; BOUNCE in the up direction reverses as above.
- Mode change takes effect on the next tick. Direction is retained when leaving and re-entering BOUNCE.
- All arithmetic is WIDTH bits with no overflow beyond `top_val`. `top_val` = 2^WIDTH-1 gives full-range counting.

## Timing
- `tick` is high during the cycle where prescaler==DIV-1. `lamps` and `wrap` update on the edge that ends that cycle.
- `wrap` is high for exactly one cycle, coincident with the new `lamps` value.
- Load: `lamps` shows the loaded value on the cycle after the edge where `load`=1. The next tick follows exactly DIV enabled cycles later.
- `en` deassert: no state changes and `tick`=0 for the whole low period. The prescaler resumes from its held value.

## Structure
- Package `lamp_counter_pkg` holds `mode_t` (2-bit enum) and the direction enum `dir_t` (UP_DIR, DOWN_DIR).
- Sub-module `tick_prescaler` (params DIV; ports `clk`, `rst_n`, `en`, `clr`, `tick`) owns the prescaler. `clr` is driven by `load`.
- The top-level wiring module instantiates the clock generator and this block, with `lamps` connected to the pins.

## Test plan
All scenarios use WIDTH=4, DIV=4, `top_val`=9 unless stated otherwise.
- Reset: assert `rst_n`=0 mid-count with `lamps`=5 → `lamps`=0, `wrap`=0, `tick`=0 immediately. After release, the first tick occurs on the 4th enabled cycle.
- UP, `en`=1: `lamps` steps 0..9, one step every 4 cycles. At cycle 40 `lamps`=0 with a single-cycle `wrap`; no other `wrap` pulses occur.
- DOWN from 0: first tick gives `lamps`=9 with `wrap`, then 8, 7, and so on. Lowering `top_val` to 3 while `lamps`=7 gives 6 on the next tick.
- BOUNCE: sequence is 0,1..9,8..0,1. `wrap` pulses only on the 9→8 and 0→1 ticks. With `top_val`=0, `lamps` stays 0 and `wrap` pulses on every tick.
- Load: `load_val`=12 loads 9. Load asserted in the same cycle as `tick` → `lamps`=`load_val`, no step, no `wrap`, and the next change occurs 4 cycles later.
- `en`=0 for 10 cycles mid-prescale: `lamps`, `tick` and `wrap` stay frozen, and the tick spacing resumes exactly. In HOLD mode `tick` keeps pulsing while `lamps` is constant and `wrap`=0.

Source files
------------

// File: rtl/lamp_counter_pkg.sv
// Shared types for the lamp counter: count mode and bounce direction.
package lamp_counter_pkg;

    // Count mode as presented on the mode port.
    typedef enum logic [1:0] {
        UP     = 2'd0,
        DOWN   = 2'd1,
        BOUNCE = 2'd2,
        HOLD   = 2'd3
    } mode_t;

    // Travel direction, meaningful in BOUNCE mode and reset to up by load/reset.
    typedef enum logic {
        UP_DIR   = 1'b0,
        DOWN_DIR = 1'b1
    } dir_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler producing a one-cycle tick enable every DIV enabled clk cycles.
// Ports: clk, rst_n (async active-low), en (run enable), clr (sync clear,
//        wins over en), tick (high while count==DIV-1 and en=1).
module tick_prescaler #(
    parameter int unsigned DIV = 8388608
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    // Gated by rst_n so tick drops immediately on reset even when DIV=1.
    assign tick = rst_n && en && (cnt == LAST);

    // Free-running modulo-DIV count, frozen while en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/lamp_counter_ctrl.sv
// Lamp counter with prescaler, programmable modulus, up/down/bounce/hold
// modes, synchronous load and a registered wrap pulse.
// Ports: clk, rst_n (async active-low), en (run enable), mode (mode_t),
//        top_val (range 0..top_val), load/load_val (sync load, clamped to
//        top_val), lamps (registered count), tick (prescaler terminal
//        pulse), wrap (one-cycle pulse on range-end event).
module lamp_counter_ctrl
    import lamp_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 8388608
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] top_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] lamps,
    output logic             tick,
    output logic             wrap
);

    dir_t             dir;
    dir_t             dir_nxt;
    logic [WIDTH-1:0] lamps_nxt;
    logic             wrap_nxt;

    // Load restarts the tick spacing so the next step is DIV enabled cycles out.
    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamps <= '0;
            dir   <= UP_DIR;
            wrap  <= 1'b0;
        end else begin
            lamps <= lamps_nxt;
            dir   <= dir_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Next-state: load beats tick; tick already includes en.
    always_comb begin
        lamps_nxt = lamps;
        dir_nxt   = dir;
        wrap_nxt  = 1'b0;

        if (load) begin
            lamps_nxt = (load_val > top_val) ? top_val : load_val;
            dir_nxt   = UP_DIR;
        end else if (tick) begin
            case (mode_t'(mode))
                UP: begin
                    // >= so a lowered top_val still wraps on the next tick.
                    if (lamps >= top_val) begin
                        lamps_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end else begin
                        lamps_nxt = lamps + WIDTH'(1);
                    end
                end
                DOWN: begin
                    if (lamps == '0) begin
                        lamps_nxt = top_val;
                        wrap_nxt  = 1'b1;
                    end else begin
                        lamps_nxt = lamps - WIDTH'(1);
                    end
                end
                BOUNCE: begin
                    if (top_val == '0) begin
                        // Degenerate range: pin at 0, every tick is an end event.
                        lamps_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end else if (dir == UP_DIR && lamps >= top_val) begin
                        lamps_nxt = top_val - WIDTH'(1);
                        dir_nxt   = DOWN_DIR;
                        wrap_nxt  = 1'b1;
                    end else if (dir == DOWN_DIR && lamps == '0) begin
                        lamps_nxt = WIDTH'(1);
                        dir_nxt   = UP_DIR;
                        wrap_nxt  = 1'b1;
                    end else if (dir == UP_DIR) begin
                        lamps_nxt = lamps + WIDTH'(1);
                    end else begin
                        lamps_nxt = lamps - WIDTH'(1);
                    end
                end
                HOLD: begin
                    lamps_nxt = lamps;
                end
                default: begin
                    lamps_nxt = lamps;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_counter_ctrl.sv
module tb_lamp_counter_ctrl;
    import lamp_counter_pkg::*;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] top_val;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] lamps;
    logic         tick;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers)
    int m_pre;
    int m_lamps;
    bit m_up;
    bit m_wrap;
    bit obs_tick;
    bit exp_tick;

    lamp_counter_ctrl #(.WIDTH(W), .DIV(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .top_val  (top_val),
        .load     (load),
        .load_val (load_val),
        .lamps    (lamps),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pre   = 0;
        m_lamps = 0;
        m_up    = 1'b1;
        m_wrap  = 1'b0;
    endfunction

    function automatic bit model_tick();
        return rst_n && en && (m_pre == D - 1);
    endfunction

    // One clock edge of the behavioural model, using the currently driven inputs.
    function automatic void model_edge();
        int t;
        int lv;
        t  = int'(top_val);
        lv = int'(load_val);
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_wrap = 1'b0;
        if (load) begin
            m_lamps = (lv < t) ? lv : t;
            m_pre   = 0;
            m_up    = 1'b1;
            return;
        end
        if (!en) return;
        if (m_pre != D - 1) begin
            m_pre = m_pre + 1;
            return;
        end
        m_pre = 0;
        case (int'(mode))
            0: if (m_lamps >= t) begin m_lamps = 0; m_wrap = 1'b1; end
               else m_lamps = m_lamps + 1;
            1: if (m_lamps == 0) begin m_lamps = t; m_wrap = 1'b1; end
               else m_lamps = m_lamps - 1;
            2: begin
                if (t == 0) begin
                    m_lamps = 0; m_wrap = 1'b1;
                end else if (m_up && m_lamps >= t) begin
                    m_lamps = t - 1; m_up = 1'b0; m_wrap = 1'b1;
                end else if (!m_up && m_lamps == 0) begin
                    m_lamps = 1; m_up = 1'b1; m_wrap = 1'b1;
                end else begin
                    m_lamps = m_up ? m_lamps + 1 : m_lamps - 1;
                end
            end
            default: ;
        endcase
    endfunction

    // Advance one cycle: sample tick mid-cycle, clock edge, model update.
    // Entered and left at posedge+1.
    task automatic step();
        #4;
        obs_tick = tick;
        exp_tick = model_tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        mode     = UP;
        top_val  = 4'd9;
        load_val = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 100 && m_lamps != 5; i++) step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (lamps !== 4'd0 || wrap !== 1'b0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: lamps=%0d wrap=%b tick=%b required 0/0/0", lamps, wrap, tick);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++;
            if (obs_tick !== (i == 4) || obs_tick !== exp_tick) begin
                bad++;
                $display("FAIL reset_first_tick: cycle %0d tick=%b required %b", i, obs_tick, (i == 4));
            end
        end
    endtask

    task automatic test_up();
        int wraps = 0;
        apply_reset();
        en = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            step();
            if (wrap) wraps++;
            total++;
            if (lamps !== 4'(m_lamps) || wrap !== m_wrap || obs_tick !== exp_tick) begin
                bad++;
                $display("FAIL up_step: c=%0d lamps=%0d wrap=%b tick=%b required %0d/%b/%b",
                         c, lamps, wrap, obs_tick, m_lamps, m_wrap, exp_tick);
            end
            if (c == 36 || c == 40) begin
                total++;
                if (lamps !== ((c == 36) ? 4'd9 : 4'd0) || wrap !== (c == 40)) begin
                    bad++;
                    $display("FAIL up_boundary: c=%0d lamps=%0d wrap=%b", c, lamps, wrap);
                end
            end
        end
        total++;
        if (wraps != 1) begin
            bad++;
            $display("FAIL up_wrap_count: got %0d required 1", wraps);
        end
    endtask

    task automatic test_down();
        apply_reset();
        mode = DOWN;
        en   = 1'b1;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (lamps !== 4'd9 || wrap !== 1'b1) begin
            bad++;
            $display("FAIL down_first: lamps=%0d wrap=%b required 9/1", lamps, wrap);
        end
        for (int i = 0; i < 40 && m_lamps != 7; i++) begin
            step();
            total++;
            if (lamps !== 4'(m_lamps) || wrap !== m_wrap) begin
                bad++;
                $display("FAIL down_step: lamps=%0d wrap=%b required %0d/%b", lamps, wrap, m_lamps, m_wrap);
            end
        end
        top_val = 4'd3;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (lamps !== 4'd6 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL down_lowered_top: lamps=%0d wrap=%b required 6/0", lamps, wrap);
        end
    endtask

    task automatic test_bounce();
        int seq [19] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        apply_reset();
        mode = BOUNCE;
        en   = 1'b1;
        for (int k = 0; k < 19; k++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                if (i < 3) begin
                    total++;
                    if (wrap !== 1'b0 || lamps !== 4'(m_lamps)) begin
                        bad++;
                        $display("FAIL bounce_idle: k=%0d lamps=%0d wrap=%b", k, lamps, wrap);
                    end
                end
            end
            total++;
            if (lamps !== 4'(seq[k]) || wrap !== (k == 9 || k == 18)) begin
                bad++;
                $display("FAIL bounce_seq: k=%0d lamps=%0d wrap=%b required %0d/%b",
                         k, lamps, wrap, seq[k], (k == 9 || k == 18));
            end
        end
        top_val  = 4'd0;
        load     = 1'b1;
        load_val = 4'd5;
        step();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) step();
            total++;
            if (lamps !== 4'd0 || wrap !== 1'b1) begin
                bad++;
                $display("FAIL bounce_top0: k=%0d lamps=%0d wrap=%b required 0/1", k, lamps, wrap);
            end
        end
    endtask

    task automatic test_load();
        apply_reset();
        load     = 1'b1;
        load_val = 4'd12;
        step();
        load = 1'b0;
        total++;
        if (lamps !== 4'd9 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_clamp: lamps=%0d wrap=%b required 9/0", lamps, wrap);
        end
        en = 1'b1;
        for (int i = 0; i < 8 && !model_tick(); i++) step();
        load     = 1'b1;
        load_val = 4'd3;
        step();
        load = 1'b0;
        total++;
        if (obs_tick !== 1'b1 || lamps !== 4'd3 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_on_tick: tick=%b lamps=%0d wrap=%b required 1/3/0", obs_tick, lamps, wrap);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            total++;
            if (obs_tick !== (i == 4) || lamps !== ((i == 4) ? 4'd4 : 4'd3)) begin
                bad++;
                $display("FAIL load_spacing: i=%0d tick=%b lamps=%0d", i, obs_tick, lamps);
            end
        end
    endtask

    task automatic test_en_freeze();
        int ticks = 0;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (lamps !== 4'd1 || obs_tick !== 1'b0 || wrap !== 1'b0) begin
                bad++;
                $display("FAIL en_frozen: i=%0d lamps=%0d tick=%b wrap=%b required 1/0/0", i, lamps, obs_tick, wrap);
            end
        end
        en = 1'b1;
        step();
        total++;
        if (obs_tick !== 1'b0) begin
            bad++;
            $display("FAIL en_resume_early: tick=%b required 0", obs_tick);
        end
        step();
        total++;
        if (obs_tick !== 1'b1 || lamps !== 4'd2) begin
            bad++;
            $display("FAIL en_resume: tick=%b lamps=%0d required 1/2", obs_tick, lamps);
        end
        mode = HOLD;
        for (int i = 0; i < 12; i++) begin
            step();
            if (obs_tick) ticks++;
            total++;
            if (lamps !== 4'd2 || wrap !== 1'b0) begin
                bad++;
                $display("FAIL hold_static: lamps=%0d wrap=%b required 2/0", lamps, wrap);
            end
        end
        total++;
        if (ticks != 3) begin
            bad++;
            $display("FAIL hold_ticks: got %0d required 3", ticks);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            en   = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) top_val = 4'($urandom_range(0, 15));
            step();
            total++;
            if (lamps !== 4'(m_lamps) || wrap !== m_wrap || obs_tick !== exp_tick) begin
                bad++;
                $display("FAIL random: c=%0d lamps=%0d wrap=%b tick=%b required %0d/%b/%b",
                         c, lamps, wrap, obs_tick, m_lamps, m_wrap, exp_tick);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        mode     = UP;
        top_val  = 4'd9;
        load_val = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_up();
        test_down();
        test_bounce();
        test_load();
        test_en_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
